pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 25 ++
 rtl/pipeline_controller.sv | 142 ++++++++++++++
 tb/tb_pipeline_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// FSM state encoding, MDU timeout and stall counter width.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam int MDU_TIMEOUT = 63;
  localparam int TMO_W       = 6;
  localparam int STALL_W     = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator.
// Flags an ID read of the register an EX-stage load writes.
module hazard_detect (
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  output logic       o_load_use
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_id_uses_rs1 &&
                  (i_id_rs1 == i_ex_rd);
  assign w_hit2 = i_id_uses_rs2 &&
                  (i_id_rs2 == i_ex_rd);

  assign o_load_use = i_ex_memread &&
                      (i_ex_rd != 5'd0) &&
                      (w_hit1 || w_hit2);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller with MDU wait FSM.
// Mealy enables, MDU timeout and stall cycle counter.
module pipeline_controller
  import pipe_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BUSYWAIT,
  input  logic [4:0]         ID_RS1,
  input  logic [4:0]         ID_RS2,
  input  logic               ID_USES_RS1,
  input  logic               ID_USES_RS2,
  input  logic [4:0]         EX_RD,
  input  logic               EX_MEMREAD,
  input  logic               EX_MDU,
  input  logic               BRANCH_TAKEN,
  input  logic               MDU_DONE,
  output logic               PC_EN,
  output logic               IF_ID_EN,
  output logic               ID_EX_EN,
  output logic               EX_MEM_EN,
  output logic               MEM_WB_EN,
  output logic               IF_ID_FLUSH,
  output logic               ID_EX_BUBBLE,
  output logic               EX_MEM_BUBBLE,
  output logic               MDU_START,
  output logic               MDU_ERR,
  output logic [STALL_W-1:0] STALL_CNT
);

  state_t             r_state;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_err;
  logic [STALL_W-1:0] r_stall;

  logic               w_load_use;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic               w_tmo_hit;

  hazard_detect u_hazard (
    .i_ex_memread  (EX_MEMREAD),
    .i_ex_rd       (EX_RD),
    .i_id_rs1      (ID_RS1),
    .i_id_rs2      (ID_RS2),
    .i_id_uses_rs1 (ID_USES_RS1),
    .i_id_uses_rs2 (ID_USES_RS2),
    .o_load_use    (w_load_use)
  );

  assign w_tmo_inc = r_tmo + 1'b1;
  assign w_tmo_hit =
    (w_tmo_inc == TMO_W'(MDU_TIMEOUT));

  // Per-cycle enables in priority order;
  // the MDU launch cycle already holds EX.
  always_comb begin
    PC_EN         = 1'b0;
    IF_ID_EN      = 1'b0;
    ID_EX_EN      = 1'b0;
    EX_MEM_EN     = 1'b0;
    MEM_WB_EN     = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    MDU_START     = 1'b0;
    if (RESET || BUSYWAIT) begin
      PC_EN = 1'b0;
    end else if (r_state == MDU_WAIT) begin
      EX_MEM_EN = 1'b1;
      MEM_WB_EN = 1'b1;
      if (MDU_DONE || w_tmo_hit) begin
        PC_EN    = 1'b1;
        IF_ID_EN = 1'b1;
        ID_EX_EN = 1'b1;
      end else begin
        EX_MEM_BUBBLE = 1'b1;
      end
    end else if (BRANCH_TAKEN) begin
      PC_EN        = 1'b1;
      IF_ID_EN     = 1'b1;
      ID_EX_EN     = 1'b1;
      EX_MEM_EN    = 1'b1;
      MEM_WB_EN    = 1'b1;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_BUBBLE = 1'b1;
    end else if (EX_MDU) begin
      EX_MEM_EN     = 1'b1;
      MEM_WB_EN     = 1'b1;
      EX_MEM_BUBBLE = 1'b1;
      MDU_START     = 1'b1;
    end else if (w_load_use) begin
      ID_EX_EN     = 1'b1;
      EX_MEM_EN    = 1'b1;
      MEM_WB_EN    = 1'b1;
      ID_EX_BUBBLE = 1'b1;
    end else begin
      PC_EN     = 1'b1;
      IF_ID_EN  = 1'b1;
      ID_EX_EN  = 1'b1;
      EX_MEM_EN = 1'b1;
      MEM_WB_EN = 1'b1;
    end
  end

  // FSM, timeout counter, sticky error and
  // saturating stall counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= RUN;
      r_tmo   <= '0;
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      if (!PC_EN && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end
      if (!BUSYWAIT) begin
        unique case (r_state)
          RUN: begin
            if (!BRANCH_TAKEN && EX_MDU) begin
              r_state <= MDU_WAIT;
              r_tmo   <= '0;
            end
          end
          MDU_WAIT: begin
            r_tmo <= w_tmo_inc;
            if (MDU_DONE) begin
              r_state <= RUN;
            end else if (w_tmo_hit) begin
              r_state <= RUN;
              r_err   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign MDU_ERR   = r_err;
  assign STALL_CNT = r_stall;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller.
// Directed scenarios plus random stimulus vs a model.
module tb_pipeline_controller;

  logic        CLK = 1'b0;
  logic        RESET, BUSYWAIT;
  logic [4:0]  ID_RS1, ID_RS2, EX_RD;
  logic        ID_USES_RS1, ID_USES_RS2;
  logic        EX_MEMREAD, EX_MDU;
  logic        BRANCH_TAKEN, MDU_DONE;
  logic        PC_EN, IF_ID_EN, ID_EX_EN;
  logic        EX_MEM_EN, MEM_WB_EN;
  logic        IF_ID_FLUSH, ID_EX_BUBBLE;
  logic        EX_MEM_BUBBLE, MDU_START;
  logic        MDU_ERR;
  logic [15:0] STALL_CNT;

  pipeline_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BUSYWAIT      (BUSYWAIT),
    .ID_RS1        (ID_RS1),
    .ID_RS2        (ID_RS2),
    .ID_USES_RS1   (ID_USES_RS1),
    .ID_USES_RS2   (ID_USES_RS2),
    .EX_RD         (EX_RD),
    .EX_MEMREAD    (EX_MEMREAD),
    .EX_MDU        (EX_MDU),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .MDU_DONE      (MDU_DONE),
    .PC_EN         (PC_EN),
    .IF_ID_EN      (IF_ID_EN),
    .ID_EX_EN      (ID_EX_EN),
    .EX_MEM_EN     (EX_MEM_EN),
    .MEM_WB_EN     (MEM_WB_EN),
    .IF_ID_FLUSH   (IF_ID_FLUSH),
    .ID_EX_BUBBLE  (ID_EX_BUBBLE),
    .EX_MEM_BUBBLE (EX_MEM_BUBBLE),
    .MDU_START     (MDU_START),
    .MDU_ERR       (MDU_ERR),
    .STALL_CNT     (STALL_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // model: waiting flag, wait cycles, error, stalls
  bit m_wait;
  int m_waited;
  bit m_err;
  int m_stall;

  int g_pc0;
  int g_start;
  int g_exb;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  task automatic idle();
    RESET = 0; BUSYWAIT = 0;
    ID_RS1 = 0; ID_RS2 = 0; EX_RD = 0;
    ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    EX_MEMREAD = 0; EX_MDU = 0;
    BRANCH_TAKEN = 0; MDU_DONE = 0;
  endtask

  // bits: pc ifid idex exmem memwb
  //       flush idbub exbub start
  task automatic tick();
    logic [8:0] e, got;
    bit lu, rel;
    @(negedge CLK);
    lu = EX_MEMREAD && EX_RD != 0 &&
         ((ID_USES_RS1 && ID_RS1 == EX_RD) ||
          (ID_USES_RS2 && ID_RS2 == EX_RD));
    rel = MDU_DONE || (m_waited + 1 >= 63);
    if (RESET || BUSYWAIT)  e = 9'b00000_000_0;
    else if (m_wait)
      e = rel ? 9'b11111_000_0 : 9'b00011_001_0;
    else if (BRANCH_TAKEN)  e = 9'b11111_110_0;
    else if (EX_MDU)        e = 9'b00011_001_1;
    else if (lu)            e = 9'b00111_010_0;
    else                    e = 9'b11111_000_0;
    got = {PC_EN, IF_ID_EN, ID_EX_EN,
           EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH,
           ID_EX_BUBBLE, EX_MEM_BUBBLE, MDU_START};
    chk("ctl", 32'(got), 32'(e));
    chk("err", 32'(MDU_ERR), 32'(m_err));
    chk("stall", 32'(STALL_CNT), 32'(m_stall));
    g_pc0   += int'(!PC_EN);
    g_start += int'(MDU_START);
    g_exb   += int'(EX_MEM_BUBBLE);
    @(posedge CLK);
    if (RESET) begin
      m_wait = 0; m_waited = 0;
      m_err = 0; m_stall = 0;
    end else begin
      if (!e[8] && m_stall < 65535) m_stall++;
      if (!BUSYWAIT) begin
        if (m_wait) begin
          m_waited++;
          if (MDU_DONE) m_wait = 0;
          else if (m_waited >= 63) begin
            m_wait = 0; m_err = 1;
          end
        end else if (!BRANCH_TAKEN && EX_MDU) begin
          m_wait = 1; m_waited = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); RESET = 1; tick(); tick(); RESET = 0;
  endtask

  initial begin
    int s0;
    logic [5:0] t0;
    idle();
    m_wait = 0; m_waited = 0;
    m_err = 0; m_stall = 0;
    RESET = 1; #1;
    @(posedge CLK); #1;
    do_reset();
    chk("rst_stall", 32'(STALL_CNT), 0);
    chk("rst_err", 32'(MDU_ERR), 0);

    // load-use: single bubble
    s0 = int'(STALL_CNT);
    EX_MEMREAD = 1; EX_RD = 5;
    ID_RS1 = 5; ID_USES_RS1 = 1;
    tick(); idle(); tick();
    chk("lu_delta", 32'(int'(STALL_CNT) - s0), 1);

    // x0 destination never stalls
    s0 = int'(STALL_CNT);
    EX_MEMREAD = 1; EX_RD = 0;
    ID_RS1 = 0; ID_USES_RS1 = 1;
    tick(); idle();
    chk("x0_delta", 32'(int'(STALL_CNT) - s0), 0);

    // branch overrides load-use
    EX_MEMREAD = 1; EX_RD = 7;
    ID_RS2 = 7; ID_USES_RS2 = 1;
    BRANCH_TAKEN = 1;
    tick(); idle();

    // MDU with done after 10 cycles
    g_pc0 = 0; g_start = 0; g_exb = 0;
    for (int i = 0; i <= 10; i++) begin
      EX_MDU = 1; MDU_DONE = (i == 10);
      tick();
    end
    idle(); tick();
    chk("mdu_pc0", 32'(g_pc0), 10);
    chk("mdu_start", 32'(g_start), 1);
    chk("mdu_exb", 32'(g_exb), 10);

    // MDU timeout, then reset clears error
    EX_MDU = 1; tick(); EX_MDU = 0;
    for (int i = 0; i < 62; i++) tick();
    chk("tmo_early", 32'(MDU_ERR), 0);
    tick();
    chk("tmo_err", 32'(MDU_ERR), 1);
    tick();
    chk("tmo_run", 32'(PC_EN), 1);
    do_reset();
    chk("tmo_clr", 32'(MDU_ERR), 0);

    // busywait freeze inside MDU_WAIT
    EX_MDU = 1; tick(); EX_MDU = 0;
    for (int i = 0; i < 5; i++) tick();
    s0 = int'(STALL_CNT);
    t0 = dut.r_tmo;
    BUSYWAIT = 1;
    for (int i = 0; i < 3; i++) tick();
    BUSYWAIT = 0;
    chk("bw_delta", 32'(int'(STALL_CNT) - s0), 3);
    chk("bw_tmo", 32'(dut.r_tmo), 32'(t0));
    MDU_DONE = 1; tick(); idle(); tick();

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      RESET        = ($urandom_range(0, 199) == 0);
      BUSYWAIT     = ($urandom_range(0, 9) == 0);
      ID_RS1       = 5'($urandom_range(0, 3));
      ID_RS2       = 5'($urandom_range(0, 3));
      EX_RD        = 5'($urandom_range(0, 3));
      ID_USES_RS1  = 1'($urandom_range(0, 1));
      ID_USES_RS2  = 1'($urandom_range(0, 1));
      EX_MEMREAD   = 1'($urandom_range(0, 1));
      EX_MDU       = ($urandom_range(0, 7) == 0);
      BRANCH_TAKEN = ($urandom_range(0, 5) == 0);
      MDU_DONE     = ($urandom_range(0, 24) == 0);
      tick();
    end
    idle(); tick();

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
